// File: rtl/spi_slave_rx_mode3.sv
// SPI mode-3 (CPOL=1, CPHA=1) slave receiver, MSB first.
// Pins are oversampled by In_clk; bytes leave as 1-cycle strobes.
module spi_slave_rx_mode3 #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              In_clk,
  input  logic              In_rst_n,
  input  logic              In_spi_cs_n,
  input  logic              In_spi_sclk,
  input  logic              In_spi_mosi,
  output logic [DATA_W-1:0] Out_rx_data,
  output logic              Out_rx_valid,
  output logic              Out_rx_busy,
  output logic              Out_rx_err
);

  localparam int CW = $clog2(DATA_W) + 1;
  localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

  typedef enum logic {
    S_IDLE,
    S_RECV
  } state_t;

  state_t r_state;

  logic [SYNC_STAGES-1:0] r_cs_sync;
  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic                   r_sclk_prev;

  logic [DATA_W-2:0] r_shift;
  logic [CW-1:0]     r_bit_cnt;
  logic [DATA_W-1:0] r_rx_data;
  logic              r_rx_valid;
  logic              r_rx_busy;
  logic              r_rx_err;

  logic              w_sync_cs_n;
  logic              w_sync_sclk;
  logic              w_sync_mosi;
  logic              w_sclk_rise;
  logic              w_accept;
  logic [DATA_W-1:0] w_next;

  assign w_sync_cs_n = r_cs_sync[SYNC_STAGES-1];
  assign w_sync_sclk = r_sclk_sync[SYNC_STAGES-1];
  assign w_sync_mosi = r_mosi_sync[SYNC_STAGES-1];
  assign w_sclk_rise = w_sync_sclk & ~r_sclk_prev;
  assign w_accept    = w_sclk_rise & ~w_sync_cs_n;
  assign w_next      = {r_shift, w_sync_mosi};

  always_ff @(posedge In_clk or negedge In_rst_n) begin
    if (!In_rst_n) begin
      r_cs_sync   <= {SYNC_STAGES{1'b1}};
      r_sclk_sync <= {SYNC_STAGES{1'b1}};
      r_mosi_sync <= '0;
      r_sclk_prev <= 1'b1;
      r_state     <= S_IDLE;
      r_shift     <= '0;
      r_bit_cnt   <= '0;
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_rx_busy   <= 1'b0;
      r_rx_err    <= 1'b0;
    end else begin
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], In_spi_cs_n};
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], In_spi_sclk};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], In_spi_mosi};
      r_sclk_prev <= w_sync_sclk;
      r_rx_valid  <= 1'b0;
      r_rx_err    <= 1'b0;
      r_rx_busy   <= ~w_sync_cs_n;

      // Edges are qualified by CS_N in the same cycle, in any state.
      if (w_accept) begin
        r_shift <= w_next[DATA_W-2:0];
        if (r_bit_cnt == LAST) begin
          r_rx_data  <= w_next;
          r_rx_valid <= 1'b1;
          r_bit_cnt  <= '0;
        end else begin
          r_bit_cnt <= r_bit_cnt + CW'(1);
        end
      end else if (w_sync_cs_n) begin
        r_bit_cnt <= '0;
      end

      unique case (r_state)
        S_IDLE: begin
          if (!w_sync_cs_n) r_state <= S_RECV;
        end
        S_RECV: begin
          if (w_sync_cs_n) begin
            r_state <= S_IDLE;
            if (r_bit_cnt != '0) r_rx_err <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign Out_rx_data  = r_rx_data;
  assign Out_rx_valid = r_rx_valid;
  assign Out_rx_busy  = r_rx_busy;
  assign Out_rx_err   = r_rx_err;

endmodule

// File: tb/tb_spi_slave_rx_mode3.sv
// Directed bench for spi_slave_rx_mode3: a behavioural mode-3
// master drives the pins; a monitor logs strobes for checking.
module tb_spi_slave_rx_mode3;

  logic       clk;
  logic       rst_n;
  logic       cs_n;
  logic       sclk;
  logic       mosi;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_busy;
  logic       rx_err;

  int n_vec  = 0;
  int n_miss = 0;

  logic [7:0] q[$];
  int errs      = 0;
  int busy_drop = 0;
  int busy_hi   = 0;
  bit in_frame  = 0;

  spi_slave_rx_mode3 #(
    .DATA_W     (8),
    .SYNC_STAGES(2)
  ) dut (
    .In_clk      (clk),
    .In_rst_n    (rst_n),
    .In_spi_cs_n (cs_n),
    .In_spi_sclk (sclk),
    .In_spi_mosi (mosi),
    .Out_rx_data (rx_data),
    .Out_rx_valid(rx_valid),
    .Out_rx_busy (rx_busy),
    .Out_rx_err  (rx_err)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  always @(negedge clk) begin
    if (rx_valid) q.push_back(rx_data);
    if (rx_err) errs++;
    if (rx_busy) busy_hi++;
    if (in_frame && !rx_busy) busy_drop++;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clr_mon;
    q.delete();
    errs      = 0;
    busy_drop = 0;
    busy_hi   = 0;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_bits(input logic [7:0] d,
                           input int nb,
                           input int half);
    for (int i = 0; i < nb; i++) begin
      sclk = 1'b0;
      mosi = d[7-i];
      wait_clk(half);
      sclk = 1'b1;
      wait_clk(half);
    end
  endtask

  task automatic cs_low(input int half);
    cs_n = 1'b0;
    wait_clk(half);
  endtask

  task automatic cs_high(input int half);
    wait_clk(half);
    cs_n = 1'b1;
    wait_clk(10);
  endtask

  initial begin
    rst_n = 1'b0;
    cs_n  = 1'b1;
    sclk  = 1'b1;
    mosi  = 1'b0;
    wait_clk(3);
    chk("rst_data", {24'd0, rx_data}, 32'h0);
    chk("rst_valid", {31'd0, rx_valid}, 32'h0);
    chk("rst_busy", {31'd0, rx_busy}, 32'h0);
    chk("rst_err", {31'd0, rx_err}, 32'h0);
    rst_n = 1'b1;
    wait_clk(5);

    // single word at 50 kHz SCLK
    clr_mon();
    cs_low(500);
    in_frame = 1'b1;
    send_bits(8'hA5, 8, 500);
    wait_clk(20);
    in_frame = 1'b0;
    cs_high(480);
    chk("w1_count", q.size(), 1);
    chk("w1_byte", {24'd0, q[0]}, 32'hA5);
    chk("w1_data", {24'd0, rx_data}, 32'hA5);
    chk("w1_err", errs, 0);
    chk("w1_busy", busy_drop, 0);
    chk("w1_idle", {31'd0, rx_busy}, 32'h0);

    // two words in one frame
    clr_mon();
    cs_low(4);
    send_bits(8'h3C, 8, 4);
    send_bits(8'hFF, 8, 4);
    cs_high(4);
    chk("w2_count", q.size(), 2);
    chk("w2_byte0", {24'd0, q[0]}, 32'h3C);
    chk("w2_byte1", {24'd0, q[1]}, 32'hFF);
    chk("w2_data", {24'd0, rx_data}, 32'hFF);
    chk("w2_err", errs, 0);

    // aborted word, then recovery
    clr_mon();
    cs_low(4);
    send_bits(8'hF0, 5, 4);
    cs_high(4);
    chk("ab_err", errs, 1);
    chk("ab_count", q.size(), 0);
    chk("ab_data", {24'd0, rx_data}, 32'hFF);
    clr_mon();
    cs_low(4);
    send_bits(8'h81, 8, 4);
    cs_high(4);
    chk("rc_count", q.size(), 1);
    chk("rc_byte", {24'd0, q[0]}, 32'h81);
    chk("rc_err", errs, 0);

    // clock activity with chip select high
    clr_mon();
    send_bits(8'hFF, 8, 4);
    send_bits(8'h00, 8, 4);
    send_bits(8'hAA, 4, 4);
    wait_clk(10);
    chk("os_count", q.size(), 0);
    chk("os_err", errs, 0);
    chk("os_busy", busy_hi, 0);
    cs_low(4);
    send_bits(8'h5A, 8, 4);
    cs_high(4);
    chk("os_byte", {24'd0, q[0]}, 32'h5A);
    chk("os_count2", q.size(), 1);

    // reset in the middle of a word
    clr_mon();
    cs_low(4);
    send_bits(8'hC3, 3, 4);
    rst_n = 1'b0;
    wait_clk(2);
    chk("mr_data", {24'd0, rx_data}, 32'h0);
    chk("mr_valid", {31'd0, rx_valid}, 32'h0);
    chk("mr_busy", {31'd0, rx_busy}, 32'h0);
    chk("mr_err", {31'd0, rx_err}, 32'h0);
    cs_n = 1'b1;
    wait_clk(4);
    rst_n = 1'b1;
    wait_clk(10);
    chk("mr_noerr", errs, 0);
    cs_low(4);
    send_bits(8'hC3, 8, 4);
    cs_high(4);
    chk("mr_count", q.size(), 1);
    chk("mr_byte", {24'd0, q[0]}, 32'hC3);
    chk("mr_err2", errs, 0);

    // loopback sweep of every byte value in one frame
    clr_mon();
    cs_low(4);
    for (int b = 0; b < 256; b++) send_bits(8'(b), 8, 4);
    cs_high(4);
    chk("lb_count", q.size(), 256);
    chk("lb_err", errs, 0);
    for (int b = 0; b < 256; b++) begin
      if (b < q.size()) chk($sformatf("lb_%0d", b), {24'd0, q[b]}, b);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
